pc_ras: RTL

- Parametrised next-generation program counter for the microprocessor datapath.
- Supports absolute load, increment, signed PC-relative branch, and call/return through an internal return-address stack (RAS).
- Sits between the control FSM, which drives the strobes, and the instruction memory address bus.
- Stall input freezes all state for multi-cycle instructions.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/ras_stack.sv | 50 +++++
 rtl/pc_ras.sv | 104 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encoding, strobe decoder and default constants for pc_ras
package pc_pkg;

    localparam int AW_DEF        = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int RESET_VEC_DEF = 0;

    typedef enum logic [2:0] {
        PC_NOP,
        PC_INCR,
        PC_BRANCH,
        PC_LOAD,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Collapse the raw strobes into one operation: RET > CALL > LOAD > BRANCH > INCR
    function automatic pc_op_e pc_decode(input logic ret, input logic call, input logic load,
                                         input logic branch, input logic incr);
        if (ret)         return PC_RET;
        else if (call)   return PC_CALL;
        else if (load)   return PC_LOAD;
        else if (branch) return PC_BRANCH;
        else if (incr)   return PC_INCR;
        else             return PC_NOP;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - DEPTH x AW return-address LIFO with occupancy count and attempt-error pulse
module ras_stack
    import pc_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              din,
    output logic [AW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [CW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = count - CW'(1);
    assign dout    = mem[top_idx[IW-1:0]];

    // Pop wins if both are requested; a refused request is reported as err
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;
    assign err     = pop ? empty : (push && full);

    // Occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       count <= '0;
        else if (do_pop)  count <= count - CW'(1);
        else if (do_push) count <= count + CW'(1);
    end

    // Entry storage; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (do_push) mem[count[IW-1:0]] <= din;
    end

endmodule

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - program counter with branch/call/return and internal RAS; PC_RAS_TRAP_EN traps stack faults to TRAP_VEC
module pc_ras
    import pc_pkg::*;
#(
    parameter int              AW        = AW_DEF,
    parameter int              DEPTH     = DEPTH_DEF,
    parameter logic [AW-1:0]   RESET_VEC = AW'(RESET_VEC_DEF),
    parameter logic [AW-1:0]   TRAP_VEC  = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    LOAD_PC,
    input  logic                    INCR_PC,
    input  logic                    BRANCH_PC,
    input  logic                    CALL,
    input  logic                    RET,
    input  logic [AW-1:0]           addr,
    input  logic [AW-1:0]           offset,
    output logic [AW-1:0]           PC,
    output logic [$clog2(DEPTH):0]  sp,
    output logic                    stack_full,
    output logic                    stack_empty,
    output logic                    stack_err
);

`ifdef PC_RAS_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic {ST_OK, ST_FAULT} fault_e;

    fault_e        state, state_next;
    pc_op_e        op;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] fault_pc;
    logic [AW-1:0] stk_dout;
    logic          push, pop, stk_err;

    assign op        = pc_decode(RET, CALL, LOAD_PC, BRANCH_PC, INCR_PC);
    assign fault_pc  = TRAP_EN ? TRAP_VEC : PC;
    assign stack_err = (state == ST_FAULT);

    ras_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (PC + AW'(1)),
        .dout  (stk_dout),
        .count (sp),
        .full  (stack_full),
        .empty (stack_empty),
        .err   (stk_err)
    );

    // Next-PC mux and stack requests; stall suppresses everything
    always_comb begin
        pc_next = PC;
        push    = 1'b0;
        pop     = 1'b0;
        if (!stall) begin
            case (op)
                PC_RET: begin
                    pop     = 1'b1;
                    pc_next = stack_empty ? fault_pc : stk_dout;
                end
                PC_CALL: begin
                    push    = 1'b1;
                    pc_next = stack_full ? fault_pc : addr;
                end
                PC_LOAD:   pc_next = addr;
                PC_BRANCH: pc_next = PC + offset;
                PC_INCR:   pc_next = PC + AW'(1);
                default:   pc_next = PC;
            endcase
        end
    end

    // Program counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) PC <= RESET_VEC;
        else        PC <= pc_next;
    end

    // Sticky fault tracker: first refused push/pop latches FAULT until reset
    always_comb begin
        state_next = state;
        case (state)
            ST_OK:    if (stk_err) state_next = ST_FAULT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_OK;
        endcase
    end

    // Fault state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_OK;
        else        state <= state_next;
    end

endmodule
